mem_arbiter: RTL and testbench

//  Shares one single-ported backing memory between I-cache and D-cache line fills/writebacks.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the I/D caches and the backing memory.
// slave: arbiter view; master: cache + memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
);
    localparam int BEAT_W = $clog2(BURST_LEN);

    logic                  i_ic_req;
    logic [ADDR_WIDTH-1:0] i_ic_addr;
    logic                  o_ic_rvalid;
    logic [DATA_WIDTH-1:0] o_ic_rdata;
    logic                  o_ic_done;

    logic                  i_dc_req;
    logic                  i_dc_wen;
    logic [ADDR_WIDTH-1:0] i_dc_addr;
    logic [DATA_WIDTH-1:0] i_dc_wdata;
    logic [BEAT_W-1:0]     o_dc_beat;
    logic                  o_dc_rvalid;
    logic [DATA_WIDTH-1:0] o_dc_rdata;
    logic                  o_dc_done;

    logic                  o_mem_req;
    logic                  o_mem_wen;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_ready;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_ic_req, i_ic_addr,
        output o_ic_rvalid, o_ic_rdata, o_ic_done,
        input  i_dc_req, i_dc_wen, i_dc_addr, i_dc_wdata,
        output o_dc_beat, o_dc_rvalid, o_dc_rdata, o_dc_done,
        output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport master (
        output i_ic_req, i_ic_addr,
        input  o_ic_rvalid, o_ic_rdata, o_ic_done,
        output i_dc_req, i_dc_wen, i_dc_addr, i_dc_wdata,
        input  o_dc_beat, o_dc_rvalid, o_dc_rdata, o_dc_done,
        input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between I-cache and D-cache line transfers (BURST_LEN beats each).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed D-cache priority.
//
// state     | meaning
// S_IDLE    | no transfer; arbitrate and latch owner/line/direction
// S_ISSUE   | o_mem_req high for current beat, waiting for i_mem_ready
// S_WAIT_RD | read beat accepted, waiting for i_mem_rvalid
// S_DONE    | owner's done pulse, back to idle
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    mem_arbiter_if.slave bus
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int OFF    = BEAT_W + 2;
    localparam int LINE_W = ADDR_WIDTH - OFF;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

    state_t                  state;
    logic                    owner_dc;
    logic                    wen;
    logic [LINE_W-1:0]       line;
    logic [BEAT_W-1:0]       beat;
    logic                    mem_req;
    logic                    mem_wen;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    ic_done;
    logic                    dc_done;

    logic                    grant_dc;
    logic [LINE_W-1:0]       req_line;
    logic                    last_beat;
    logic [BEAT_W-1:0]       beat_nxt;
    logic                    rd_fwd;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [LINE_W-1:0] l,
                                                        input logic [BEAT_W-1:0] b);
        return {l, b, 2'b00};
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dc;
    assign grant_dc = bus.i_dc_req && (!bus.i_ic_req || !last_dc);
`else
    assign grant_dc = bus.i_dc_req;
`endif

    assign req_line  = grant_dc ? bus.i_dc_addr[ADDR_WIDTH-1:OFF] : bus.i_ic_addr[ADDR_WIDTH-1:OFF];
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
    assign beat_nxt  = beat + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            owner_dc <= 1'b0;
            wen      <= 1'b0;
            line     <= '0;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            ic_done  <= 1'b0;
            dc_done  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dc  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_ic_req || bus.i_dc_req) begin
                        owner_dc <= grant_dc;
                        wen      <= grant_dc && bus.i_dc_wen;
                        line     <= req_line;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_wen  <= grant_dc && bus.i_dc_wen;
                        mem_addr <= beat_addr(req_line, '0);
                        state    <= S_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_dc  <= grant_dc;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.i_mem_ready) begin
                        if (wen && !last_beat) begin
                            beat     <= beat_nxt;
                            mem_addr <= beat_addr(line, beat_nxt);
                        end else begin
                            mem_req  <= 1'b0;
                            mem_wen  <= 1'b0;
                            mem_addr <= '0;
                            if (wen) begin
                                beat    <= '0;
                                ic_done <= !owner_dc;
                                dc_done <= owner_dc;
                                state   <= S_DONE;
                            end else begin
                                state   <= S_WAIT_RD;
                            end
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (bus.i_mem_rvalid) begin
                        if (last_beat) begin
                            beat    <= '0;
                            ic_done <= !owner_dc;
                            dc_done <= owner_dc;
                            state   <= S_DONE;
                        end else begin
                            beat     <= beat_nxt;
                            mem_req  <= 1'b1;
                            mem_addr <= beat_addr(line, beat_nxt);
                            state    <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    ic_done <= 1'b0;
                    dc_done <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Read data passes straight through to the owner in the cycle memory returns it.
    assign rd_fwd = (state == S_WAIT_RD) && bus.i_mem_rvalid;

    assign bus.o_ic_rvalid = rd_fwd && !owner_dc;
    assign bus.o_ic_rdata  = (rd_fwd && !owner_dc) ? bus.i_mem_rdata : '0;
    assign bus.o_ic_done   = ic_done;
    assign bus.o_dc_rvalid = rd_fwd && owner_dc;
    assign bus.o_dc_rdata  = (rd_fwd && owner_dc) ? bus.i_mem_rdata : '0;
    assign bus.o_dc_done   = dc_done;
    assign bus.o_dc_beat   = beat;
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_wen   = mem_wen;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = (state == S_ISSUE && wen) ? bus.i_dc_wdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple one-cycle-latency memory model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus ();
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    assign bus.i_dc_wdata = 32'(bus.o_dc_beat) * 32'h11;

    function automatic logic [DW-1:0] mem_pat(input logic [AW-1:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // memory model: read data returned the cycle after the beat is accepted
    int          stall_left = 0;
    logic [1:0]  stall_beat = 2'd0;
    logic        prev_rd_acc;
    logic [AW-1:0] prev_addr;
    initial begin
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        prev_rd_acc = 1'b0;
        prev_addr   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_mem_rvalid = prev_rd_acc;
            bus.i_mem_rdata  = prev_rd_acc ? mem_pat(prev_addr) : '0;
            if (stall_left > 0 && bus.o_mem_req && bus.o_mem_addr[3:2] == stall_beat) begin
                bus.i_mem_ready = 1'b0;
                stall_left--;
            end else begin
                bus.i_mem_ready = 1'b1;
            end
            prev_rd_acc = bus.o_mem_req && bus.i_mem_ready && !bus.o_mem_wen;
            prev_addr   = bus.o_mem_addr;
        end
    end

    // monitor
    int            cyc = 0;
    logic [AW-1:0] acc_addr  [0:255];
    logic          acc_wen   [0:255];
    logic [DW-1:0] acc_wdata [0:255];
    int            acc_cyc   [0:255];
    int            acc_n = 0;
    logic [DW-1:0] ic_rd [0:255];
    logic [DW-1:0] dc_rd [0:255];
    int            ic_n = 0, dc_n = 0;
    int            ic_done_n = 0, dc_done_n = 0;
    logic          done_seq [0:255];
    int            done_n = 0;
    int            dc_done_cyc = 0;
    int            stable_err = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    initial begin
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (prev_stall && !(bus.o_mem_req && bus.o_mem_addr == stall_addr)) stable_err++;
            prev_stall = bus.o_mem_req && !bus.i_mem_ready;
            stall_addr = bus.o_mem_addr;
            if (bus.o_mem_req && bus.i_mem_ready && acc_n < 256) begin
                acc_addr[acc_n]  = bus.o_mem_addr;
                acc_wen[acc_n]   = bus.o_mem_wen;
                acc_wdata[acc_n] = bus.o_mem_wdata;
                acc_cyc[acc_n]   = cyc;
                acc_n++;
            end
            if (bus.o_ic_rvalid && ic_n < 256) begin ic_rd[ic_n] = bus.o_ic_rdata; ic_n++; end
            if (bus.o_dc_rvalid && dc_n < 256) begin dc_rd[dc_n] = bus.o_dc_rdata; dc_n++; end
            if (bus.o_ic_done && done_n < 256) begin
                ic_done_n++; done_seq[done_n] = 1'b0; done_n++;
            end
            if (bus.o_dc_done && done_n < 256) begin
                dc_done_n++; done_seq[done_n] = 1'b1; done_n++; dc_done_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [135:0] all_out();
        return {bus.o_ic_rvalid, bus.o_ic_rdata, bus.o_ic_done, bus.o_dc_beat,
                bus.o_dc_rvalid, bus.o_dc_rdata, bus.o_dc_done, bus.o_mem_req,
                bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_ic_req = 1'b0;
        bus.i_dc_req = 1'b0;
        bus.i_dc_wen = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out());
        end
        tick(3);
        checks++;
        if (acc_n !== 0) begin
            failures++;
            $display("FAIL reset_idle_mem got=%0d exp=0", acc_n);
        end
    endtask

    task automatic test_i_fill();
        int base = acc_n, ic0 = ic_n, dc0 = dc_n, icd0 = ic_done_n, dcd0 = dc_done_n, lat = 0;
        bus.i_ic_addr = 32'h1004;
        bus.i_ic_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (ic_done_n > icd0) break;
        end
        bus.i_ic_req = 1'b0;
        tick(3);
        // grant + 2 cycles per beat + DONE, observed from the negedge before the grant cycle ends
        checks++;
        if (lat !== 2 * BL + 1) begin
            failures++; $display("FAIL ifill_latency got=%0d exp=%0d", lat, 2 * BL + 1);
        end
        checks++;
        if (acc_n - base !== BL) begin
            failures++; $display("FAIL ifill_beats got=%0d exp=%0d", acc_n - base, BL);
        end
        for (int k = 0; k < BL; k++) begin
            checks++;
            if (acc_addr[base+k] !== 32'h1000 + 32'(4 * k) || acc_wen[base+k] !== 1'b0) begin
                failures++;
                $display("FAIL ifill_addr%0d got=%h wen=%b exp=%h wen=0", k, acc_addr[base+k],
                         acc_wen[base+k], 32'h1000 + 32'(4 * k));
            end
            checks++;
            if (ic_rd[ic0+k] !== mem_pat(32'h1000 + 32'(4 * k))) begin
                failures++;
                $display("FAIL ifill_rdata%0d got=%h exp=%h", k, ic_rd[ic0+k],
                         mem_pat(32'h1000 + 32'(4 * k)));
            end
        end
        checks++;
        if (ic_n - ic0 !== BL || dc_n !== dc0) begin
            failures++; $display("FAIL ifill_rvalid ic=%0d dc=%0d exp ic=%0d dc=0", ic_n - ic0, dc_n - dc0, BL);
        end
        checks++;
        if (ic_done_n !== icd0 + 1 || dc_done_n !== dcd0) begin
            failures++; $display("FAIL ifill_done ic=%0d dc=%0d exp ic=1 dc=0", ic_done_n - icd0, dc_done_n - dcd0);
        end
    endtask

    task automatic test_d_writeback();
        int base = acc_n, ic0 = ic_n, dc0 = dc_n, icd0 = ic_done_n, dcd0 = dc_done_n;
        bit ok = 1'b0;
        bus.i_dc_addr = 32'h2000;
        bus.i_dc_wen  = 1'b1;
        bus.i_dc_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dc_done_n > dcd0) begin ok = 1'b1; break; end
        end
        bus.i_dc_req = 1'b0;
        bus.i_dc_wen = 1'b0;
        tick(3);
        checks++;
        if (!ok) begin failures++; $display("FAIL dwb_done_timeout got=0 exp=1"); end
        checks++;
        if (acc_n - base !== BL) begin
            failures++; $display("FAIL dwb_beats got=%0d exp=%0d", acc_n - base, BL);
        end
        for (int k = 0; k < BL; k++) begin
            checks++;
            if (acc_addr[base+k] !== 32'h2000 + 32'(4 * k) || acc_wen[base+k] !== 1'b1 ||
                acc_wdata[base+k] !== 32'(k) * 32'h11) begin
                failures++;
                $display("FAIL dwb_beat%0d got addr=%h wen=%b data=%h exp addr=%h wen=1 data=%h", k,
                         acc_addr[base+k], acc_wen[base+k], acc_wdata[base+k],
                         32'h2000 + 32'(4 * k), 32'(k) * 32'h11);
            end
        end
        checks++;
        if (ic_n !== ic0 || ic_done_n !== icd0 || dc_n !== dc0 || dc_done_n !== dcd0 + 1) begin
            failures++;
            $display("FAIL dwb_side_effects ic_rv=%0d ic_done=%0d dc_rv=%0d dc_done=%0d exp 0 0 0 1",
                     ic_n - ic0, ic_done_n - icd0, dc_n - dc0, dc_done_n - dcd0);
        end
    endtask

    task automatic test_priority();
        int base, ic0, dc0, dn0;
        bit ok = 1'b0;
        do_reset();
        base = acc_n; ic0 = ic_n; dc0 = dc_n; dn0 = done_n;
        bus.i_ic_addr = 32'h3000;
        bus.i_dc_addr = 32'h4000;
        bus.i_dc_wen  = 1'b0;
        bus.i_ic_req  = 1'b1;
        bus.i_dc_req  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dc_done_n > 0 && done_n > dn0) bus.i_dc_req = 1'b0;
            if (done_n >= dn0 + 2) begin ok = 1'b1; break; end
        end
        bus.i_ic_req = 1'b0;
        bus.i_dc_req = 1'b0;
        tick(3);
        checks++;
        if (!ok || done_seq[dn0] !== 1'b1 || done_seq[dn0+1] !== 1'b0) begin
            failures++;
            $display("FAIL prio_done_order got=%b%b ok=%b exp=10 ok=1", done_seq[dn0], done_seq[dn0+1], ok);
        end
        checks++;
        if (acc_addr[base] !== 32'h4000 || acc_addr[base+BL] !== 32'h3000) begin
            failures++;
            $display("FAIL prio_first_beats got d=%h i=%h exp d=4000 i=3000", acc_addr[base], acc_addr[base+BL]);
        end
        checks++;
        if (acc_cyc[base+BL] - dc_done_cyc !== 2) begin
            failures++;
            $display("FAIL prio_idle_gap got=%0d exp=2", acc_cyc[base+BL] - dc_done_cyc);
        end
        checks++;
        if (ic_n - ic0 !== BL || dc_n - dc0 !== BL) begin
            failures++; $display("FAIL prio_rvalid ic=%0d dc=%0d exp=%0d each", ic_n - ic0, dc_n - dc0, BL);
        end
    endtask

    task automatic test_back_to_back();
        int dn0;
        bit ok = 1'b0;
        logic exp;
        do_reset();
        dn0 = done_n;
        bus.i_ic_addr = 32'h5000;
        bus.i_dc_addr = 32'h6000;
        bus.i_dc_wen  = 1'b0;
        bus.i_ic_req  = 1'b1;
        bus.i_dc_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_n >= dn0 + 3) begin ok = 1'b1; break; end
        end
        bus.i_ic_req = 1'b0;
        bus.i_dc_req = 1'b0;
        tick(4);
        checks++;
        if (!ok || done_n !== dn0 + 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", done_n - dn0);
        end
        for (int k = 0; k < 3; k++) begin
            exp = RR ? ((k % 2) == 0) : 1'b1;
            checks++;
            if (done_seq[dn0+k] !== exp) begin
                failures++; $display("FAIL b2b_grant%0d got=%b exp=%b (1=D)", k, done_seq[dn0+k], exp);
            end
        end
    endtask

    task automatic test_stall();
        int base = acc_n, ic0 = ic_n, icd0 = ic_done_n, lat = 0;
        stable_err = 0;
        stall_beat = 2'd2;
        stall_left = 5;
        bus.i_ic_addr = 32'h7000;
        bus.i_ic_req  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (ic_done_n > icd0) break;
        end
        bus.i_ic_req = 1'b0;
        tick(3);
        checks++;
        if (lat !== 2 * BL + 1 + 5 || stall_left !== 0) begin
            failures++; $display("FAIL stall_latency got=%0d left=%0d exp=%0d left=0", lat, stall_left, 2 * BL + 6);
        end
        checks++;
        if (stable_err !== 0) begin
            failures++; $display("FAIL stall_hold got=%0d exp=0", stable_err);
        end
        checks++;
        if (acc_n - base !== BL || ic_n - ic0 !== BL) begin
            failures++; $display("FAIL stall_beats acc=%0d rv=%0d exp=%0d", acc_n - base, ic_n - ic0, BL);
        end
        for (int k = 0; k < BL; k++) begin
            checks++;
            if (acc_addr[base+k] !== 32'h7000 + 32'(4 * k) || ic_rd[ic0+k] !== mem_pat(32'h7000 + 32'(4 * k))) begin
                failures++;
                $display("FAIL stall_beat%0d got addr=%h data=%h exp addr=%h", k, acc_addr[base+k],
                         ic_rd[ic0+k], 32'h7000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, ic0, icd0, dcd0;
        bit found = 1'b0, ok = 1'b0;
        icd0 = ic_done_n;
        dcd0 = dc_done_n;
        bus.i_ic_addr = 32'h8000;
        bus.i_ic_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_mem_req && bus.o_mem_addr == 32'h8004) begin found = 1'b1; break; end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!found || all_out() !== '0) begin
            failures++; $display("FAIL rstmid_outputs found=%b got=%h exp=0", found, all_out());
        end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++;
        if (ic_done_n !== icd0 || dc_done_n !== dcd0) begin
            failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ic_done_n + dc_done_n - icd0 - dcd0);
        end
        base = acc_n - 1;
        ic0 = ic_n;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ic_done_n > icd0) begin ok = 1'b1; break; end
        end
        bus.i_ic_req = 1'b0;
        tick(3);
        checks++;
        if (!ok || acc_n - base !== BL || ic_n - ic0 !== BL) begin
            failures++;
            $display("FAIL rstmid_restart ok=%b acc=%0d rv=%0d exp ok=1 %0d %0d", ok, acc_n - base, ic_n - ic0, BL, BL);
        end
        for (int k = 0; k < BL; k++) begin
            checks++;
            if (acc_addr[base+k] !== 32'h8000 + 32'(4 * k)) begin
                failures++;
                $display("FAIL rstmid_addr%0d got=%h exp=%h", k, acc_addr[base+k], 32'h8000 + 32'(4 * k));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_ic_req  = 1'b0;
        bus.i_ic_addr = '0;
        bus.i_dc_req  = 1'b0;
        bus.i_dc_wen  = 1'b0;
        bus.i_dc_addr = '0;
        tick(1);
        test_reset();
        test_i_fill();
        test_d_writeback();
        test_priority();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
